// File: rtl/bsg_source_sync_downstream_receiver_pkg.sv
// Shared definitions for the source-synchronous downstream receiver.
// Holds the FIFO operation encoding used to update occupancy. Link
// parameters are deliberately not defined here: they are passed explicitly
// so that the receiver and transmitter credit math stay in lock step.
package bsg_source_sync_downstream_receiver_pkg;

    // {enq, deq} packed into one selector for the occupancy update
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_DEQ  = 2'b01,
        FIFO_OP_ENQ  = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/bsg_source_sync_token_gen.sv
// Credit-to-token converter for the source-synchronous link.
// Every dequeue returns one credit. Credits accumulate in a small counter;
// when a full group of 2^lg_credit_to_token_decimation_p credits has been
// collected the token line toggles, so each token edge (rising or falling)
// stands for one group. Residual partial credits are held until the group
// completes.
//   clk_i      : link clock
//   reset_n_i  : asynchronous active-low reset (token held low)
//   deq_i      : one credit returned this cycle
//   token_r_o  : registered token line to the transmitter
module bsg_source_sync_token_gen #(
    parameter int lg_credit_to_token_decimation_p = 3
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic deq_i,
    output logic token_r_o
);

    localparam int lp_cw = lg_credit_to_token_decimation_p;
    localparam logic [lp_cw-1:0] lp_cnt_max = {lp_cw{1'b1}};
    localparam logic [lp_cw-1:0] lp_cnt_one = lp_cw'(1);

    logic [lp_cw-1:0] r_credit_cnt;
    logic             r_token;

    // Credit accumulation and token toggle on group completion
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_credit_cnt <= {lp_cw{1'b0}};
            r_token      <= 1'b0;
        end else if (deq_i) begin
            if (r_credit_cnt == lp_cnt_max) begin
                r_credit_cnt <= {lp_cw{1'b0}};
                r_token      <= ~r_token;
            end else begin
                r_credit_cnt <= r_credit_cnt + lp_cnt_one;
                r_token      <= r_token;
            end
        end else begin
            r_credit_cnt <= r_credit_cnt;
            r_token      <= r_token;
        end
    end

    assign token_r_o = r_token;

endmodule

// File: rtl/bsg_source_sync_downstream_receiver.sv
// Receiving end of the source-synchronous link.
// Incoming words are registered in a capture stage, then written into a
// 2^lg_fifo_depth_p deep FIFO read by the core. Dequeues are converted to
// credits and returned to the transmitter on a toggling token line.
//   clk_i        : link clock, all state on posedge
//   reset_n_i    : asynchronous active-low reset
//   io_data_i    : incoming word (meaningful only with io_valid_i)
//   io_valid_i   : incoming word valid
//   core_data_o  : FIFO head data (zero while empty)
//   core_valid_o : FIFO non-empty
//   core_yumi_i  : core consumes the head this cycle
//   token_r_o    : registered token line back to the transmitter
//   overflow_r_o : sticky, a word arrived while the FIFO was full
//   count_r_o    : FIFO occupancy
module bsg_source_sync_downstream_receiver
    import bsg_source_sync_downstream_receiver_pkg::*;
#(
    parameter int channel_width_p                 = 16,
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [channel_width_p-1:0] io_data_i,
    input  logic                       io_valid_i,
    output logic [channel_width_p-1:0] core_data_o,
    output logic                       core_valid_o,
    input  logic                       core_yumi_i,
    output logic                       token_r_o,
    output logic                       overflow_r_o,
    output logic [lg_fifo_depth_p:0]   count_r_o
);

    localparam int lp_depth = 1 << lg_fifo_depth_p;
    localparam logic [lg_fifo_depth_p:0]   lp_full_count = (lg_fifo_depth_p+1)'(lp_depth);
    localparam logic [lg_fifo_depth_p:0]   lp_count_one  = (lg_fifo_depth_p+1)'(1);
    localparam logic [lg_fifo_depth_p-1:0] lp_ptr_one    = lg_fifo_depth_p'(1);

    logic                       r_io_valid;
    logic [channel_width_p-1:0] r_io_data;
    logic [channel_width_p-1:0] r_mem [lp_depth];
    logic [lg_fifo_depth_p-1:0] r_wr_ptr;
    logic [lg_fifo_depth_p-1:0] r_rd_ptr;
    logic [lg_fifo_depth_p:0]   r_count;
    logic                       r_overflow;

    logic                       w_full;
    logic                       w_empty;
    logic                       w_enq;
    logic                       w_deq;
    fifo_op_e                   w_op;

    // Full/empty come from registered occupancy only, so a same-cycle
    // dequeue never frees a slot for a same-cycle enqueue.
    assign w_full  = (r_count == lp_full_count);
    assign w_empty = (r_count == {(lg_fifo_depth_p+1){1'b0}});
    assign w_enq   = r_io_valid & ~w_full;
    assign w_deq   = core_yumi_i & ~w_empty;
    assign w_op    = fifo_op_e'({w_enq, w_deq});

    // Capture stage for the incoming channel
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_io_valid <= 1'b0;
            r_io_data  <= {channel_width_p{1'b0}};
        end else begin
            r_io_valid <= io_valid_i;
            r_io_data  <= io_data_i;
        end
    end

    // FIFO storage: synchronous write, contents need no reset
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= r_io_data;
        end
    end

    // Write/read pointers, wrapping modulo the FIFO depth
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= {lg_fifo_depth_p{1'b0}};
            r_rd_ptr <= {lg_fifo_depth_p{1'b0}};
        end else begin
            r_wr_ptr <= w_enq ? (r_wr_ptr + lp_ptr_one) : r_wr_ptr;
            r_rd_ptr <= w_deq ? (r_rd_ptr + lp_ptr_one) : r_rd_ptr;
        end
    end

    // Occupancy update: enq and deq together leave the count unchanged
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= {(lg_fifo_depth_p+1){1'b0}};
        end else begin
            case (w_op)
                FIFO_OP_ENQ: r_count <= r_count + lp_count_one;
                FIFO_OP_DEQ: r_count <= r_count - lp_count_one;
                default:     r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a captured word met a full FIFO and was dropped
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_overflow <= 1'b0;
        end else if (r_io_valid & w_full) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    bsg_source_sync_token_gen #(
        .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p)
    ) u_token_gen (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .deq_i    (w_deq),
        .token_r_o(token_r_o)
    );

    // Head data is forced to zero while empty so stale storage never leaks
    assign core_data_o  = w_empty ? {channel_width_p{1'b0}} : r_mem[r_rd_ptr];
    assign core_valid_o = ~w_empty;
    assign overflow_r_o = r_overflow;
    assign count_r_o    = r_count;

endmodule

// File: tb/tb_bsg_source_sync_downstream_receiver.sv
// Self-checking bench for bsg_source_sync_downstream_receiver.
// A behavioural model (capture register, word queue, credit counter,
// token, overflow) predicts every cycle; accepted words are pushed to a
// scoreboard queue and popped/compared when the core consumes them.
module tb_bsg_source_sync_downstream_receiver;

    localparam int W     = 16;
    localparam int LG    = 6;
    localparam int LGC   = 3;
    localparam int DEPTH = 1 << LG;
    localparam int GROUP = 1 << LGC;

    logic          clk_i;
    logic          reset_n_i;
    logic [W-1:0]  io_data_i;
    logic          io_valid_i;
    logic [W-1:0]  core_data_o;
    logic          core_valid_o;
    logic          core_yumi_i;
    logic          token_r_o;
    logic          overflow_r_o;
    logic [LG:0]   count_r_o;

    int n_checks;
    int n_fail;

    logic [W-1:0] sb[$];
    logic         m_cap_v;
    logic [W-1:0] m_cap_d;
    int           m_cred;
    logic         m_tok;
    logic         m_ovf;

    bsg_source_sync_downstream_receiver #(
        .channel_width_p                (W),
        .lg_fifo_depth_p                (LG),
        .lg_credit_to_token_decimation_p(LGC)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .io_data_i   (io_data_i),
        .io_valid_i  (io_valid_i),
        .core_data_o (core_data_o),
        .core_valid_o(core_valid_o),
        .core_yumi_i (core_yumi_i),
        .token_r_o   (token_r_o),
        .overflow_r_o(overflow_r_o),
        .count_r_o   (count_r_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare DUT state with the model, drive one cycle, advance the model.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic y);
        logic full;
        logic [W-1:0] exp_head;
        check("valid", {31'd0, core_valid_o}, {31'd0, (sb.size() != 0)});
        check("count", {25'd0, count_r_o}, sb.size());
        check("token", {31'd0, token_r_o}, {31'd0, m_tok});
        check("ovf", {31'd0, overflow_r_o}, {31'd0, m_ovf});
        if (sb.size() == 0) check("data_empty", {16'd0, core_data_o}, 32'd0);
        io_valid_i  = v;
        io_data_i   = d;
        core_yumi_i = y;
        full = (sb.size() == DEPTH);
        if (y && sb.size() != 0) begin
            exp_head = sb.pop_front();
            check("sb_pop", {16'd0, core_data_o}, {16'd0, exp_head});
            if (m_cred == GROUP - 1) begin
                m_cred = 0;
                m_tok  = ~m_tok;
            end else begin
                m_cred = m_cred + 1;
            end
        end
        if (m_cap_v) begin
            if (!full) sb.push_back(m_cap_d);
            else       m_ovf = 1'b1;
        end
        m_cap_v = v;
        m_cap_d = d;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        io_valid_i  = 1'b0;
        io_data_i   = '0;
        core_yumi_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_valid", {31'd0, core_valid_o}, 32'd0);
        check("rst_data", {16'd0, core_data_o}, 32'd0);
        check("rst_count", {25'd0, count_r_o}, 32'd0);
        check("rst_token", {31'd0, token_r_o}, 32'd0);
        check("rst_ovf", {31'd0, overflow_r_o}, 32'd0);
        sb.delete();
        m_cap_v = 1'b0;
        m_cap_d = '0;
        m_cred  = 0;
        m_tok   = 1'b0;
        m_ovf   = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n_i   = 1'b0;
        io_valid_i  = 1'b0;
        io_data_i   = '0;
        core_yumi_i = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Latency: pulse 0x1234, visible two edges later, then consume
        cycle(1'b1, 16'h1234, 1'b0);
        check("lat_k", {31'd0, core_valid_o}, 32'd0);
        cycle(1'b0, 16'h0000, 1'b0);
        check("lat_k1_valid", {31'd0, core_valid_o}, 32'd1);
        check("lat_k1_data", {16'd0, core_data_o}, 32'h1234);
        cycle(1'b0, 16'h0000, 1'b1);
        check("lat_drained", {25'd0, count_r_o}, 32'd0);

        // Reset mid-stream with 5 words queued
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'hA000 + i), 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        check("pre_rst_count", {25'd0, count_r_o}, 32'd5);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0);

        // Token cadence: 24 words, deq 16 (toggle at 8 and 16), 3 more, then 5
        for (int i = 0; i < 24; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            if (i == 6)  check("tok_7th", {31'd0, token_r_o}, 32'd0);
            if (i == 7)  check("tok_8th", {31'd0, token_r_o}, 32'd1);
            if (i == 15) check("tok_16th", {31'd0, token_r_o}, 32'd0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1);
        check("tok_partial", {31'd0, token_r_o}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1);
        check("tok_held_7", {31'd0, token_r_o}, 32'd0);
        cycle(1'b0, 16'h0000, 1'b1);
        check("tok_held_8", {31'd0, token_r_o}, 32'd1);

        // Full/overflow: 65 back-to-back words, then drain 1..64
        do_reset();
        for (int i = 1; i <= 65; i++) cycle(1'b1, 16'(i), 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        check("full_count", {25'd0, count_r_o}, 32'd64);
        check("full_ovf", {31'd0, overflow_r_o}, 32'd1);
        for (int i = 0; i < 64; i++) cycle(1'b0, 16'h0000, 1'b1);
        check("ovf_sticky", {31'd0, overflow_r_o}, 32'd1);

        // Simultaneous arrival and yumi at full: word dropped, count 63
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        check("sim_count", {25'd0, count_r_o}, 32'd63);
        check("sim_ovf", {31'd0, overflow_r_o}, 32'd1);
        for (int i = 0; i < 63; i++) cycle(1'b0, 16'h0000, 1'b1);

        // Idle yumi: no count or token change
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000, 1'b1);
        check("idle_token", {31'd0, token_r_o}, 32'd0);

        // Continuous flow: enq and deq every cycle
        for (int i = 0; i < 40; i++) cycle(1'b1, 16'(16'h5A00 + i), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
